prf_read_arbiter: RTL and testbench
===================================

// Module: prf_read_arbiter
// PURPOSE
//   Shares the physical-register-file read ports among the reservation stations (ALU, MUL/DIV, ...).
//   Each RS raises prf_req when it holds a ready entry; this block returns same-cycle grants, at most
//   one per read-port pair, with rotating priority plus a starvation override.
//   Sits between the RS array and the PRF read mux; grant_port steers each granted RS onto its port.
// PARAMETERS
//   NUM_REQ      4  number of requesting reservation stations
//   NUM_PORTS    2  number of PRF read-port pairs (rs1+rs2) available per cycle
//   STARVE_LIMIT 8  consecutive denied cycles after which a requester is marked starved
// PORTS
//   clk             in   1                          clock
//   rst             in   1                          synchronous reset, active-high
//   flush           in   1                          pipeline flush (branch mispredict / exception)
//   req             in   NUM_REQ                    prf_req from each RS, bit i = RS i
//   port_block      in   NUM_PORTS                  port j unavailable this cycle (e.g. debug/commit read)
//   grant           out  NUM_REQ                    prf_grant to each RS
//   grant_port      out  NUM_REQ*$clog2(NUM_PORTS)  port index for RS i, valid only when grant[i]
//   grant_count     out  $clog2(NUM_PORTS)+1        number of grants this cycle
//   starved         out  NUM_REQ                    registered starvation flags (profiling/debug)
// BEHAVIOUR
//   State: rr_ptr ($clog2(NUM_REQ) bits); starve_cnt[i] ($clog2(STARVE_LIMIT+1) bits, saturating).
//   Reset (rst=1 at posedge): rr_ptr=0, all starve_cnt=0, starved=0. While rst is high grant=0,
//     grant_port=0, grant_count=0 (combinational outputs gated by rst).
//   Grant is combinational, zero latency: grant[i] may be 1 only if req[i]=1 in the same cycle.
//   Free ports = ports with port_block[j]=0; assigned in ascending j order to winners in selection order.
//   Selection order each cycle:
//     1. starved requesters (starve_cnt==STARVE_LIMIT), ascending index;
//     2. remaining requesters, round-robin starting at rr_ptr, wrapping NUM_REQ-1 -> 0.
//   Winners = first min(#requesters, #free ports) in that order; no requester granted twice.
//   grant_count = popcount(grant); never exceeds NUM_PORTS or free-port count.
//   All ports blocked -> no grants; counters still update (denied requesters increment).
//   rr_ptr update (posedge, no rst/flush): if any round-robin-phase grant, rr_ptr <= (index of last
//     round-robin-phase winner + 1) mod NUM_REQ; else unchanged. Starvation-phase grants do not move it.
//   starve_cnt[i] update: req[i]&!grant[i] -> +1 saturating at STARVE_LIMIT; grant[i] or !req[i] -> 0.
//   starved[i] register = (next starve_cnt[i]==STARVE_LIMIT).
//   flush: same cycle grants still computed normally (RS ignores via its own flush); at posedge all
//     starve_cnt and starved cleared, rr_ptr <= 0. rst has priority over flush.
//   A grant consumed without issue (RS execute_ready low) counts as granted: counter clears.
//   Guarantee: any requester holding req continuously is granted within STARVE_LIMIT+NUM_REQ cycles
//     provided at least one port is unblocked each cycle.
//   NUM_PORTS >= NUM_REQ: every requester granted every cycle, counters stay 0.
//   No X on outputs for any req/port_block combination; grant_port for non-granted i is 0.
// TESTING
//   Reset: rst=1 with req=4'b1111 -> grant=0, grant_count=0; after release rr_ptr=0, starved=0.
//   RR: req=4'b1111, port_block=0 held 3 cycles -> grant 4'b0011, 4'b1100, 4'b0011; ports 0,1 in order.
//   Blocking: req=4'b0110, port_block=2'b01 -> grant=4'b0010, grant_port[1]=1, grant_count=1.
//   Starvation: RS3 req held, RS0-2 saturate 1 port (port_block=2'b10) with rr forced away; after 8
//     denials starved[3]=1 and next cycle grant[3]=1, starve_cnt[3] -> 0.
//   Flush: starve_cnt[2]=5, rr_ptr=3, flush=1 -> next cycle counters 0, rr_ptr=0; grants that cycle normal.
//   Random: 10k cycles random req/port_block -> grant subset of req, count<=free ports, bound held.

Source files
------------

// File: rtl/prf_read_arbiter_if.sv
// Request/grant bundle between the reservation-station array and the PRF read arbiter.
// The RS side drives requests, flush and port blocks; the arbiter returns grants and port steering.
interface prf_read_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int GW = $clog2(NUM_PORTS) + 1;

  logic                  flush;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_PORTS-1:0]  port_block;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ*PW-1:0] grant_port;
  logic [GW-1:0]         grant_count;
  logic [NUM_REQ-1:0]    starved;

  modport master (
    output flush, req, port_block,
    input  grant, grant_port, grant_count, starved
  );

  modport slave (
    input  flush, req, port_block,
    output grant, grant_port, grant_count, starved
  );
endinterface

// File: rtl/prf_read_arbiter.sv
// Shares PRF read-port pairs among reservation stations: zero-latency grants, rotating priority with starvation override.
// No backpressure path: a denied RS keeps req high; per-RS denial counters and rr_ptr are the only state.
module prf_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_PORTS    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst,
  prf_read_arbiter_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int GW = $clog2(NUM_PORTS) + 1;
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [RW-1:0]         rr_ptr;
  logic [RW-1:0]         rr_nxt;
  logic [RW-1:0]         rr_last;
  logic                  rr_hit;
  logic [CW-1:0]         starve_cnt [NUM_REQ];
  logic [CW-1:0]         cnt_nxt    [NUM_REQ];
  logic [NUM_REQ-1:0]    starved_q;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ*PW-1:0] gport;
  logic [PW-1:0]         free_idx   [NUM_PORTS];
  int                    free_n;
  int                    win_n;
  int                    idx;

  // Free ports are packed into free_idx in ascending order; the n-th winner takes free_idx[n].
  always_comb begin
    gnt     = '0;
    gport   = '0;
    free_n  = 0;
    win_n   = 0;
    idx     = 0;
    rr_hit  = 1'b0;
    rr_last = '0;
    for (int j = 0; j < NUM_PORTS; j++) free_idx[j] = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!bus.port_block[j]) begin
        free_idx[free_n] = PW'(j);
        free_n = free_n + 1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i] && starve_cnt[i] == LIMIT && win_n < free_n) begin
        gnt[i]             = 1'b1;
        gport[i*PW +: PW]  = free_idx[win_n];
        win_n              = win_n + 1;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[idx] && !gnt[idx] && win_n < free_n) begin
        gnt[idx]            = 1'b1;
        gport[idx*PW +: PW] = free_idx[win_n];
        win_n               = win_n + 1;
        rr_hit              = 1'b1;
        rr_last             = RW'(idx);
      end
    end
    if (rst) begin
      gnt   = '0;
      gport = '0;
    end
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (rr_hit) begin
      if (int'(rr_last) == NUM_REQ - 1) rr_nxt = '0;
      else                              rr_nxt = rr_last + 1'b1;
    end
  end

  // A grant clears the counter even if the RS cannot issue that cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] || !bus.req[i])      cnt_nxt[i] = '0;
      else if (starve_cnt[i] == LIMIT) cnt_nxt[i] = LIMIT;
      else                             cnt_nxt[i] = starve_cnt[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rr_ptr    <= '0;
      starved_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      for (int i = 0; i < NUM_REQ; i++) begin
        starve_cnt[i] <= cnt_nxt[i];
        starved_q[i]  <= (cnt_nxt[i] == LIMIT);
      end
    end
  end

  assign bus.grant       = gnt;
  assign bus.grant_port  = gport;
  assign bus.grant_count = GW'($countones(gnt));
  assign bus.starved     = starved_q;
endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed and randomized checks for prf_read_arbiter with 4 requesters and 2 read-port pairs.
module tb_prf_read_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int NUM_PORTS    = 2;
  localparam int STARVE_LIMIT = 8;
  localparam int PW           = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wait_cnt [NUM_REQ];

  always #5 clk = ~clk;

  prf_read_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS)) bus ();

  prf_read_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after a posedge; outputs are sampled at the following negedge.
  task automatic apply(input logic [3:0] r, input logic [1:0] pb, input logic f);
    bus.req        = r;
    bus.port_block = pb;
    bus.flush      = f;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [3:0] gp, input logic [2:0] c);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
    chk({tag, "_port"},  32'(bus.grant_port), 32'(gp));
    chk({tag, "_count"}, 32'(bus.grant_count), 32'(c));
  endtask

  initial begin
    int free_n;
    int exp_n;
    int k;
    int worst;
    logic ok;
    logic [1:0] used;
    logic [3:0] r;
    logic [1:0] pb;
    logic p;

    bus.req = '0; bus.port_block = '0; bus.flush = 1'b0;
    tick();

    // Reset gating of combinational outputs
    apply(4'b1111, 2'b00, 1'b0);
    chk_grant("rst", 4'b0000, 4'b0000, 3'd0);
    tick();
    chk("rst_starved", 32'(bus.starved), 32'h0);
    rst = 1'b0;

    // Round robin with both ports free
    apply(4'b1111, 2'b00, 1'b0); chk_grant("rr1", 4'b0011, 4'b0010, 3'd2); tick();
    apply(4'b1111, 2'b00, 1'b0); chk_grant("rr2", 4'b1100, 4'b1000, 3'd2); tick();
    apply(4'b1111, 2'b00, 1'b0); chk_grant("rr3", 4'b0011, 4'b0010, 3'd2); tick();

    // Port 0 blocked: single grant steered to port 1
    apply(4'b0000, 2'b00, 1'b1); chk_grant("fl0", 4'b0000, 4'b0000, 3'd0); tick();
    apply(4'b0110, 2'b01, 1'b0); chk_grant("blk", 4'b0010, 4'b0010, 3'd1); tick();

    // Starvation of RS3 under fully blocked ports, then priority override
    apply(4'b0000, 2'b00, 1'b1); tick();
    apply(4'b0001, 2'b00, 1'b0); chk_grant("pre", 4'b0001, 4'b0000, 3'd1); tick();
    for (int i = 0; i < 7; i++) begin
      apply(4'b1000, 2'b11, 1'b0); chk("allblk_grant", 32'(bus.grant), 32'h0); tick();
    end
    chk("starve7", 32'(bus.starved), 32'h0);
    apply(4'b1000, 2'b11, 1'b0); tick();
    chk("starve8", 32'(bus.starved), 32'h8);
    apply(4'b1000, 2'b11, 1'b0); tick();
    apply(4'b1000, 2'b11, 1'b0); tick();
    chk("starve_sat", 32'(bus.starved), 32'h8);
    apply(4'b1111, 2'b00, 1'b0); chk_grant("spri", 4'b1010, 4'b0010, 3'd2); tick();
    chk("starve_clr", 32'(bus.starved), 32'h0);
    apply(4'b1111, 2'b00, 1'b0); chk_grant("spost", 4'b1100, 4'b1000, 3'd2); tick();

    // Flush with rr_ptr=3 and starve_cnt[2]=5
    apply(4'b0100, 2'b00, 1'b0); chk_grant("fset", 4'b0100, 4'b0000, 3'd1); tick();
    for (int i = 0; i < 5; i++) begin
      apply(4'b0100, 2'b11, 1'b0); tick();
    end
    apply(4'b1111, 2'b00, 1'b1); chk_grant("fcyc", 4'b1001, 4'b0001, 3'd2); tick();
    chk("flush_starved", 32'(bus.starved), 32'h0);
    apply(4'b1111, 2'b00, 1'b0); chk_grant("fpost", 4'b0011, 4'b0010, 3'd2); tick();
    for (int i = 0; i < 6; i++) begin
      apply(4'b0100, 2'b11, 1'b0); tick();
    end
    chk("fcnt7", 32'(bus.starved), 32'h0);
    apply(4'b0100, 2'b11, 1'b0); tick();
    chk("fcnt8", 32'(bus.starved), 32'h4);

    // Random traffic with at least one free port each cycle
    apply(4'b0000, 2'b00, 1'b1); tick();
    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      r  = 4'($urandom_range(0, 15));
      pb = 2'($urandom_range(0, 2));
      apply(r, pb, 1'b0);
      free_n = (pb[0] ? 0 : 1) + (pb[1] ? 0 : 1);
      exp_n  = ($countones(r) < free_n) ? $countones(r) : free_n;
      chk("rnd_subset", 32'(bus.grant & ~r), 32'h0);
      chk("rnd_count", 32'(bus.grant_count), 32'($countones(bus.grant)));
      chk("rnd_work", 32'($countones(bus.grant)), 32'(exp_n));
      ok = 1'b1; used = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        p = bus.grant_port[i*PW];
        if (bus.grant[i]) begin
          if (pb[p] || used[p]) ok = 1'b0;
          used[p] = 1'b1;
        end else if (p !== 1'b0) begin
          ok = 1'b0;
        end
      end
      chk("rnd_port", 32'(ok), 32'h1);
      ok = 1'b1; k = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.starved[i] && r[i]) begin
          if (k < free_n && !bus.grant[i]) ok = 1'b0;
          k++;
        end
      end
      chk("rnd_starve_pri", 32'(ok), 32'h1);
      worst = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r[i] && !bus.grant[i]) wait_cnt[i]++;
        else                       wait_cnt[i] = 0;
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      chk("rnd_bound", 32'(worst > STARVE_LIMIT + NUM_REQ), 32'h0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
